// File: rtl/md_sequencer_pkg.sv
// Shared decode constants, FSM-to-datapath control bundle and helpers for the
// MIPS-Lite multiply/divide sequencer.
package md_sequencer_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [4:0] LAST_STEP = 5'd31;

    // Strobes from the sequencer FSM into md_datapath.
    typedef struct packed {
        logic load;       // start cycle: latch operands, mode and sign flags
        logic div_op;     // valid with load: divide rather than multiply
        logic signed_op;  // valid with load: MULT/DIV rather than MULTU/DIVU
        logic step;       // one shift-add or restoring-divide iteration
        logic fix;        // sign correction of the finished result
        logic wr;         // copy corrected result into HI/LO
        logic wr_hi;      // MTHI
        logic wr_lo;      // MTLO
    } md_ctrl_t;

    function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Shift pair, shared 33-bit adder/subtractor, sign correction and the HI/LO
// architectural registers, all sequenced by strobes from md_sequencer.
module md_datapath
    import md_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  md_ctrl_t    ctrl,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] acc_q, acc_d;
    logic [31:0] shf_q, shf_d;
    logic [31:0] opd_q, opd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div_q, div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;

    logic        rs_neg, rt_neg;
    logic [32:0] add_a, add_b, add_sum;
    logic        add_cin;
    logic [63:0] prod_neg;

    // Multiply adds mcand into {0,acc}; divide subtracts the divisor from the
    // remainder shifted left by one dividend bit.
    always_comb begin
        if (div_q) begin
            add_a   = {acc_q, shf_q[31]};
            add_b   = ~{1'b0, opd_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q};
            add_b   = shf_q[0] ? {1'b0, opd_q} : 33'd0;
            add_cin = 1'b0;
        end
        add_sum  = add_a + add_b + {32'd0, add_cin};
        prod_neg = ~{acc_q, shf_q} + 64'd1;
        rs_neg   = ctrl.signed_op & rs[31];
        rt_neg   = ctrl.signed_op & rt[31];
    end

    always_comb begin
        acc_d  = acc_q;
        shf_d  = shf_q;
        opd_d  = opd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;

        if (ctrl.load) begin
            acc_d  = 32'd0;
            div_d  = ctrl.div_op;
            neg_d  = rs_neg ^ rt_neg;
            rneg_d = rs_neg;
            dz_d   = (rt == 32'd0);
            shf_d  = ctrl.div_op ? cond_neg(rs_neg, rs) : cond_neg(rt_neg, rt);
            opd_d  = ctrl.div_op ? cond_neg(rt_neg, rt) : cond_neg(rs_neg, rs);
        end

        if (ctrl.step) begin
            if (!div_q) begin
                acc_d = add_sum[32:1];
                shf_d = {add_sum[0], shf_q[31:1]};
            end else if (!add_sum[32]) begin
                acc_d = add_sum[31:0];
                shf_d = {shf_q[30:0], 1'b1};
            end else begin
                acc_d = add_a[31:0];
                shf_d = {shf_q[30:0], 1'b0};
            end
        end

        // Divide by zero leaves the dividend magnitude in acc; only LO is forced.
        if (ctrl.fix) begin
            if (!div_q) begin
                if (neg_q) begin
                    {acc_d, shf_d} = prod_neg;
                end
            end else begin
                shf_d = dz_q ? 32'hFFFF_FFFF : cond_neg(neg_q, shf_q);
                acc_d = cond_neg(rneg_q, acc_q);
            end
        end

        if (ctrl.wr) begin
            hi_d = acc_q;
            lo_d = shf_q;
        end
        if (ctrl.wr_hi) begin
            hi_d = rs;
        end
        if (ctrl.wr_lo) begin
            lo_d = rs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 32'd0;
            shf_q  <= 32'd0;
            opd_q  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            shf_q  <= shf_d;
            opd_q  <= opd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the EX stage: decodes the HI/LO instructions,
// runs the 32-step sequence FSM and stalls the pipeline while busy.
module md_sequencer
    import md_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IR,
    input  logic        Issue,
    input  logic [31:0] RSbus,
    input  logic [31:0] RTbus,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Result,
    output logic        ResultSel
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    md_ctrl_t   ctrl;

    logic [5:0] fn;
    logic       special;
    logic       dec_mul, dec_div, dec_mfhi, dec_mflo, dec_mthi, dec_mtlo, dec_any;
    logic       unused_ir;

    assign fn        = IR[5:0];
    assign special   = Issue && (IR[31:26] == OP_SPECIAL);
    assign unused_ir = ^IR[25:6];

    always_comb begin
        dec_mul  = special && (fn == FN_MULT || fn == FN_MULTU);
        dec_div  = special && (fn == FN_DIV  || fn == FN_DIVU);
        dec_mfhi = special && (fn == FN_MFHI);
        dec_mflo = special && (fn == FN_MFLO);
        dec_mthi = special && (fn == FN_MTHI);
        dec_mtlo = special && (fn == FN_MTLO);
        dec_any  = dec_mul | dec_div | dec_mfhi | dec_mflo | dec_mthi | dec_mtlo;
    end

    assign Busy      = (state_q != S_IDLE);
    assign Stall     = Busy && dec_any;
    assign ResultSel = (dec_mfhi || dec_mflo) && !Stall;
    assign Result    = (dec_mfhi && !Stall) ? HI :
                       (dec_mflo && !Stall) ? LO : 32'd0;

    // Busy is exactly "not IDLE", so anything decoded in IDLE is unstalled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = '0;
        unique case (state_q)
            S_IDLE: begin
                ctrl.wr_hi = dec_mthi;
                ctrl.wr_lo = dec_mtlo;
                if (dec_mul || dec_div) begin
                    ctrl.load      = 1'b1;
                    ctrl.div_op    = dec_div;
                    ctrl.signed_op = (fn == FN_MULT) || (fn == FN_DIV);
                    cnt_d          = 5'd0;
                    state_d        = dec_div ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                ctrl.step = 1'b1;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                ctrl.fix = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                ctrl.wr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    md_datapath u_dp (
        .clk   (CLK),
        .rst_n (RESET_N),
        .ctrl  (ctrl),
        .rs    (RSbus),
        .rt    (RTbus),
        .hi    (HI),
        .lo    (LO)
    );

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and randomized bench for md_sequencer against an arithmetic
// reference model of MULT/MULTU/DIV/DIVU and the HI/LO move instructions.
module tb_md_sequencer;

    localparam logic [5:0] T_MFHI  = 6'h10;
    localparam logic [5:0] T_MTHI  = 6'h11;
    localparam logic [5:0] T_MFLO  = 6'h12;
    localparam logic [5:0] T_MTLO  = 6'h13;
    localparam logic [5:0] T_MULT  = 6'h18;
    localparam logic [5:0] T_MULTU = 6'h19;
    localparam logic [5:0] T_DIV   = 6'h1A;
    localparam logic [5:0] T_DIVU  = 6'h1B;
    localparam logic [5:0] T_ADD   = 6'h20;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] IR;
    logic        Issue;
    logic [31:0] RSbus;
    logic [31:0] RTbus;
    logic        Stall;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;
    logic        ResultSel;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    md_sequencer dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IR        (IR),
        .Issue     (Issue),
        .RSbus     (RSbus),
        .RTbus     (RTbus),
        .Stall     (Stall),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .Result    (Result),
        .ResultSel (ResultSel)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, HI then LO pushed to exp_q
    task automatic model_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            T_MULT:  p = 64'(sa * sb);
            T_MULTU: p = {32'd0, a} * {32'd0, b};
            T_DIV:   p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        exp_q.push_back(p[63:32]);
        exp_q.push_back(p[31:0]);
    endtask

    // Drivers
    task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        IR    = {6'h00, 20'h0, fn};
        Issue = 1'b1;
        RSbus = a;
        RTbus = b;
    endtask

    task automatic idle_in();
        Issue = 1'b0;
        IR    = 32'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts Busy cycles from the current cycle; returns at the first idle negedge.
    task automatic wait_busy(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (!Busy) break;
            n++;
            tick();
        end
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (!Stall) break;
            n++;
            tick();
        end
    endtask

    task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        int n;
        model_md(fn, a, b);
        drive(fn, a, b);
        @(negedge CLK);
        check({tag, " stall_at_issue"}, 32'(Stall), 32'd0);
        tick();
        idle_in();
        wait_busy(n);
        check({tag, " busy_cycles"}, 32'(n), 32'd34);
        check({tag, " hi"}, HI, exp_q.pop_front());
        check({tag, " lo"}, LO, exp_q.pop_front());
        tick();
    endtask

    initial begin
        int n;
        logic [5:0] fns[4];
        logic [31:0] a, b, exp_hi, exp_lo;
        fns[0] = T_MULT; fns[1] = T_MULTU; fns[2] = T_DIV; fns[3] = T_DIVU;

        // Reset state
        RESET_N = 1'b0;
        idle_in();
        RSbus = 32'd0;
        RTbus = 32'd0;
        #3;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        check("reset stall", 32'(Stall), 32'd0);
        check("reset resultsel", 32'(ResultSel), 32'd0);
        #9;
        RESET_N = 1'b1;
        tick();

        // Directed arithmetic cases
        run_md("mult_neg2x3", T_MULT, 32'hFFFF_FFFE, 32'd3);
        run_md("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2);
        run_md("divu_7_0", T_DIVU, 32'd7, 32'd0);
        run_md("div_m7_0", T_DIV, 32'hFFFF_FFF9, 32'd0);
        run_md("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_7_m2", T_DIV, 32'd7, 32'hFFFF_FFFE);
        run_md("mult_minxmin", T_MULT, 32'h8000_0000, 32'h8000_0000);

        // Randomized arithmetic
        for (int i = 0; i < 10; i++) begin
            logic [5:0] f;
            f = fns[$urandom_range(0, 3)];
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            run_md("random", f, a, b);
        end

        // MULT, ADD during Busy, then MFLO one cycle later
        a = $urandom;
        b = $urandom;
        model_md(T_MULT, a, b);
        exp_hi = exp_q.pop_front();
        exp_lo = exp_q.pop_front();
        drive(T_MULT, a, b);
        tick();
        drive(T_ADD, 32'd1, 32'd2);
        @(negedge CLK);
        check("add_during_busy stall", 32'(Stall), 32'd0);
        check("add_during_busy resultsel", 32'(ResultSel), 32'd0);
        check("add_during_busy busy", 32'(Busy), 32'd1);
        tick();
        drive(T_MFLO, 32'd0, 32'd0);
        wait_stall(n);
        check("mflo stall_cycles", 32'(n), 32'd33);
        check("mflo resultsel", 32'(ResultSel), 32'd1);
        check("mflo result", Result, exp_lo);
        tick();
        drive(T_MFHI, 32'd0, 32'd0);
        @(negedge CLK);
        check("mfhi result", Result, exp_hi);
        tick();
        idle_in();

        // Back-to-back MULT: second stalls until Busy drops, then runs
        a = $urandom;
        b = $urandom;
        model_md(T_MULT, a, b);
        drive(T_MULT, a, b);
        tick();
        a = $urandom;
        b = $urandom;
        model_md(T_MULT, a, b);
        drive(T_MULT, a, b);
        wait_stall(n);
        check("b2b stall_cycles", 32'(n), 32'd34);
        check("b2b first hi", HI, exp_q.pop_front());
        check("b2b first lo", LO, exp_q.pop_front());
        tick();
        idle_in();
        wait_busy(n);
        check("b2b second busy_cycles", 32'(n), 32'd34);
        check("b2b second hi", HI, exp_q.pop_front());
        check("b2b second lo", LO, exp_q.pop_front());
        tick();

        // MTLO during a DIV is held off until the result is written
        drive(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        drive(T_MTLO, 32'hDEAD_BEEF, 32'd0);
        wait_stall(n);
        check("mtlo stall_cycles", 32'(n), 32'd34);
        check("mtlo lo_before", LO, 32'h8000_0000);
        check("mtlo hi_before", HI, 32'd0);
        tick();
        idle_in();
        @(negedge CLK);
        check("mtlo lo_after", LO, 32'hDEAD_BEEF);
        tick();

        // Asynchronous reset mid-DIV, then MTHI
        drive(T_DIV, $urandom, 32'd3);
        tick();
        idle_in();
        repeat (16) tick();
        #2;
        RESET_N = 1'b0;
        #1;
        check("midreset busy", 32'(Busy), 32'd0);
        check("midreset hi", HI, 32'd0);
        check("midreset lo", LO, 32'd0);
        check("midreset stall", 32'(Stall), 32'd0);
        check("midreset resultsel", 32'(ResultSel), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        drive(T_MTHI, 32'h0000_1234, 32'd0);
        @(negedge CLK);
        check("mthi stall", 32'(Stall), 32'd0);
        tick();
        idle_in();
        @(negedge CLK);
        check("mthi hi", HI, 32'h0000_1234);
        check("mthi busy", 32'(Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
